wallace_mac_seq: RTL and testbench

Sequencing controller that wraps one `wallace_4x4_pipelined` multiplier and turns it into a streaming multiply-accumulate engine. It accepts 4-bit operand pairs over a valid/ready handshake and issues one pair per cycle into the multiplier pipeline. In-flight products are tracked against the fixed multiplier latency and summed into an accumulator. On the last term it drains the pipeline and presents the dot-product result on a valid/ready output. It sits between the operand source (FIFO or vector loader) and the MAC result consumer in the MAC subsystem.

---
 rtl/wallace_mac_seq.sv | 219 +++++++++++++++++++++
 tb/tb_wallace_mac_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mac_seq.sv
// wallace_mac_seq: streaming multiply-accumulate controller.
//
// Accepts 4-bit operand pairs over a valid/ready handshake and issues one pair
// per cycle into a three-stage Wallace-tree multiplier. A shift register
// tracks the pairs in flight so that each product is added to the accumulator
// exactly MUL_LAT cycles after it was accepted. The job ends on the pair that
// carries in_last, or when MAX_TERMS pairs have been taken. The pipeline then
// drains, and the dot product is held on out_acc/out_count until out_ready.
//
// Optional feature: define MAC_SAT_EN to clamp the accumulator at all-ones and
// raise a sticky out_sat. Without it the sum wraps and out_sat is tied to 0.
//
// Ports (wallace_mac_seq):
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  controller can take a pair (IDLE or RUN)
//   in_a       in   4-bit multiplicand
//   in_b       in   4-bit multiplier
//   in_last    in   pair is the final term of the job
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer takes the result
//   out_acc    out  accumulated sum, ACC_W bits
//   out_count  out  number of terms accumulated, CNT_W bits
//   out_sat    out  saturation occurred
//
// Ports (wallace_4x4_pipelined):
//   clk in, rst in (sync, active-high, clears the valid pipe only),
//   vld_i in, a_i/b_i in (4 bits), prod_o out (8 bits, zero when not valid)

module wallace_4x4_pipelined (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] prod_o
);
  // The reduction tree below is written for exactly four partial-product rows.
  localparam int DATA_W = 4;
  localparam int PW     = 2 * DATA_W;

  function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] x, y, z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x, y, z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [PW-1:0] pp_p0 [DATA_W];
  logic [PW-1:0] s_p1, c_p1, prod_p2;
  logic [PW-1:0] s_l1, c_l1, s_l2, c_l2;
  logic          vld_p0, vld_p1, vld_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= vld_i;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_comb begin
    s_l1 = csa_sum(pp_p0[0], pp_p0[1], pp_p0[2]);
    c_l1 = csa_carry(pp_p0[0], pp_p0[1], pp_p0[2]);
    s_l2 = csa_sum(s_l1, c_l1, pp_p0[3]);
    c_l2 = csa_carry(s_l1, c_l1, pp_p0[3]);
  end

  always_ff @(posedge clk) begin
    // stage p0: partial-product rows
    for (int i = 0; i < DATA_W; i++) begin
      pp_p0[i] <= PW'(a_i & {DATA_W{b_i[i]}}) << i;
    end
    // stage p1: two 3:2 compressor layers, four rows down to sum/carry
    s_p1 <= s_l2;
    c_p1 <= c_l2;
    // stage p2: final carry-propagate add
    prod_p2 <= s_p1 + c_p1;
  end

  assign prod_o = vld_p2 ? prod_p2 : '0;

endmodule

module wallace_mac_seq #(
  parameter int MUL_LAT   = 3,
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Full-width sum; the extra top bit is the overflow flag.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                             input logic [7:0] prod);
    return {1'b0, acc} + {1'b0, ACC_W'(prod)};
  endfunction

  function automatic logic [ACC_W-1:0] acc_sat(input logic [ACC_W:0] sum);
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  endfunction

  logic [1:0]         state_q, state_d;
  logic [MUL_LAT-1:0] vld_q, vld_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W:0]     sum;
  logic [3:0]         mul_a, mul_b;
  logic [7:0]         prod;
  logic               accept, retire, end_job;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_RUN);
  assign accept   = in_valid && in_ready && rst_n;
  assign retire   = vld_q[MUL_LAT-1];
  // The pair that fills the counter closes the job even without in_last.
  assign end_job  = in_last || (cnt_q == CNT_W'(MAX_TERMS - 1));
  // Idle cycles feed zeros so the pipe carries nothing stale.
  assign mul_a    = accept ? in_a : 4'd0;
  assign mul_b    = accept ? in_b : 4'd0;
  assign sum      = acc_add(acc_q, prod);

  wallace_4x4_pipelined u_mul (
    .clk    (clk),
    .rst    (~rst_n),
    .vld_i  (accept),
    .a_i    (mul_a),
    .b_i    (mul_b),
    .prod_o (prod)
  );

`ifdef MAC_SAT_EN
  logic sat_q, sat_d;
`endif

  always_comb begin
    state_d = state_q;
    vld_d   = {vld_q[MUL_LAT-2:0], accept};
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef MAC_SAT_EN
    sat_d   = sat_q;
    if (retire) begin
      acc_d = acc_sat(sum);
      sat_d = sat_q | sum[ACC_W];
    end
`else
    if (retire) acc_d = sum[ACC_W-1:0];
`endif
    if (accept) cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE, S_RUN: if (accept) state_d = end_job ? S_DRAIN : S_RUN;
      // Leave DRAIN on the edge that retires the last pair still in flight.
      S_DRAIN: if (vld_q[MUL_LAT-2:0] == '0) state_d = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef MAC_SAT_EN
          sat_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vld_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef MAC_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef MAC_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign out_acc   = acc_q;
  assign out_count = cnt_q;
`ifdef MAC_SAT_EN
  assign out_sat   = sat_q;
`else
  assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_wallace_mac_seq.sv
module tb_wallace_mac_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] vin;
  logic [3:0] in_a, in_b;
  logic       in_last, out_ready;
  logic [2:0] rdy, ov;

  // m: default build, u: ACC_W = 8, f: MAX_TERMS = 4
  logic [15:0] m_acc;
  logic [8:0]  m_cnt;
  logic        m_sat;
  logic [7:0]  u_acc;
  logic [8:0]  u_cnt;
  logic        u_sat;
  logic [15:0] f_acc;
  logic [2:0]  f_cnt;
  logic        f_sat;

  typedef struct { int acc; int cnt; int sat; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  wallace_mac_seq dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(vin[0]), .in_ready(rdy[0]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov[0]),
    .out_ready(out_ready), .out_acc(m_acc), .out_count(m_cnt), .out_sat(m_sat)
  );

  wallace_mac_seq #(.ACC_W(8)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(vin[1]), .in_ready(rdy[1]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov[1]),
    .out_ready(out_ready), .out_acc(u_acc), .out_count(u_cnt), .out_sat(u_sat)
  );

  wallace_mac_seq #(.MAX_TERMS(4)) dut_f (
    .clk(clk), .rst_n(rst_n), .in_valid(vin[2]), .in_ready(rdy[2]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov[2]),
    .out_ready(out_ready), .out_acc(f_acc), .out_count(f_cnt), .out_sat(f_sat)
  );

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Compares a presented result with the head of the queue; pops on handshake.
  task automatic mon_cmp(input string tag, input exp_t e, input int acc,
                         input int cnt, input int sat, input int ready);
    check({tag, "_acc"}, acc, e.acc);
    check({tag, "_count"}, cnt, e.cnt);
    check({tag, "_sat"}, sat, e.sat);
    check({tag, "_in_ready_in_done"}, ready, 0);
  endtask

  always @(negedge clk) if (ov[0]) begin
    if (q0.size() == 0) check("m_unexpected_result", 1, 0);
    else begin
      mon_cmp("m", q0[0], int'(m_acc), int'(m_cnt), int'(m_sat), int'(rdy[0]));
      if (out_ready) void'(q0.pop_front());
    end
  end

  always @(negedge clk) if (ov[1]) begin
    if (q1.size() == 0) check("u_unexpected_result", 1, 0);
    else begin
      mon_cmp("u", q1[0], int'(u_acc), int'(u_cnt), int'(u_sat), int'(rdy[1]));
      if (out_ready) void'(q1.pop_front());
    end
  end

  always @(negedge clk) if (ov[2]) begin
    if (q2.size() == 0) check("f_unexpected_result", 1, 0);
    else begin
      mon_cmp("f", q2[0], int'(f_acc), int'(f_cnt), int'(f_sat), int'(rdy[2]));
      if (out_ready) void'(q2.pop_front());
    end
  end

  // Offers one pair to instance d and returns 1 ns after the accepting edge.
  task automatic send(input int d, input logic [3:0] a, input logic [3:0] b,
                      input logic last);
    int n = 0;
    in_a = a; in_b = b; in_last = last; vin[d] = 1'b1;
    @(negedge clk);
    while (!rdy[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) check("send_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    vin[d] = 1'b0; in_last = 1'b0; in_a = 4'd0; in_b = 4'd0;
  endtask

  // Counts edges from the last accept until out_valid rises.
  task automatic wait_valid(input int d, input string nm, input int exp_lat);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ov[d] && n < 50);
    check(nm, n, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; vin = 3'b000; in_a = 4'd0; in_b = 4'd0;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(rdy), 7);
    check("rst_out_valid", int'(ov), 0);
    check("rst_m_acc", int'(m_acc), 0);
    check("rst_m_count", int'(m_cnt), 0);
    check("rst_m_sat", int'(m_sat), 0);
    check("rst_u_acc", int'(u_acc), 0);
    check("rst_f_count", int'(f_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pair 15*15
    e = '{225, 1, 0}; q0.push_back(e);
    send(0, 4'd15, 4'd15, 1'b1);
    wait_valid(0, "t1_latency", 3);
    @(posedge clk);
    #1;
    check("t1_release_valid", int'(ov[0]), 0);
    check("t1_release_acc", int'(m_acc), 0);
    check("t1_release_count", int'(m_cnt), 0);
    check("t1_release_in_ready", int'(rdy[0]), 1);

    // Back-to-back stream, sum of i*(15-i) = 560
    e = '{560, 16, 0}; q0.push_back(e);
    for (int i = 0; i < 16; i++) send(0, 4'(i), 4'(15 - i), i == 15);
    wait_valid(0, "t2_latency", 3);
    repeat (2) @(posedge clk);
    #1;

    // Gaps and back-pressure: 12 + 30 + 49 = 91
    e = '{91, 3, 0}; q0.push_back(e);
    send(0, 4'd3, 4'd4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send(0, 4'd5, 4'd6, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(0, 4'd7, 4'd7, 1'b1);
    wait_valid(0, "t3_latency", 3);
    repeat (5) @(posedge clk);
    #1;
    check("t3_held_valid", int'(ov[0]), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_released_valid", int'(ov[0]), 0);

    // Reset mid-operation: one pair retired, two in flight
    send(0, 4'd2, 4'd2, 1'b0);
    send(0, 4'd3, 4'd3, 1'b0);
    send(0, 4'd4, 4'd4, 1'b0);
    @(posedge clk);
    #1;
    check("t6_pre_acc", int'(m_acc), 4);
    check("t6_pre_count", int'(m_cnt), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_acc", int'(m_acc), 0);
    check("t6_rst_count", int'(m_cnt), 0);
    check("t6_rst_in_ready", int'(rdy[0]), 1);
    check("t6_rst_valid", int'(ov[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e = '{6, 1, 0}; q0.push_back(e);
    send(0, 4'd2, 4'd3, 1'b1);
    wait_valid(0, "t6_fresh_latency", 3);
    repeat (2) @(posedge clk);
    #1;

    // Overflow with ACC_W = 8: 450
`ifdef MAC_SAT_EN
    e = '{255, 2, 1};
`else
    e = '{194, 2, 0};
`endif
    q1.push_back(e);
    send(1, 4'd15, 4'd15, 1'b0);
    send(1, 4'd15, 4'd15, 1'b1);
    wait_valid(1, "t4_latency", 3);
    repeat (2) @(posedge clk);
    #1;

    // Forced last with MAX_TERMS = 4; fifth pair opens the next job
    e = '{4, 4, 0}; q2.push_back(e);
    e = '{2, 2, 0}; q2.push_back(e);
    for (int i = 0; i < 4; i++) send(2, 4'd1, 4'd1, 1'b0);
    check("t5_ready_drop", int'(rdy[2]), 0);
    send(2, 4'd1, 4'd1, 1'b0);
    send(2, 4'd1, 4'd1, 1'b1);
    wait_valid(2, "t5_second_latency", 3);

    repeat (10) @(posedge clk);
    #1;
    check("q_m_left", q0.size(), 0);
    check("q_u_left", q1.size(), 0);
    check("q_f_left", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
